// File: rtl/pic_control_sequencer_if.sv
// Host bus, ISR handshake and command-word bundle for the PIC control sequencer.
// master = host/ISR side, slave = sequencer.
interface pic_control_sequencer_if;
  logic       wrEn;
  logic       a0;
  logic [7:0] dataIn;
  logic       rdEn;
  logic       intaN;
  logic       irqPending;
  logic       readPriorityAck;
  logic       sendVectorAck;
  logic       changeInOCW2Ack;
  logic       INT;
  logic       readPriority;
  logic       sendVector;
  logic       secondACK;
  logic       changeInOCW2;
  logic       readIsr;
  logic       dataBusEn;
  logic       initDone;
  logic       ackError;
  logic [7:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3;

  modport master (
    output wrEn, a0, dataIn, rdEn, intaN, irqPending,
           readPriorityAck, sendVectorAck, changeInOCW2Ack,
    input  INT, readPriority, sendVector, secondACK, changeInOCW2, readIsr,
           dataBusEn, initDone, ackError, ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3
  );

  modport slave (
    input  wrEn, a0, dataIn, rdEn, intaN, irqPending,
           readPriorityAck, sendVectorAck, changeInOCW2Ack,
    output INT, readPriority, sendVector, secondACK, changeInOCW2, readIsr,
           dataBusEn, initDone, ackError, ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3
  );
endinterface

// File: rtl/pic_control_sequencer.sv
// 8259A-style control sequencer: ICW/OCW registers, init FSM, two-pulse INTA FSM
// and toggle-acknowledged requests to the in-service register, each with a timeout.
module pic_control_sequencer #(
  parameter int ACK_TIMEOUT = 15
) (
  input logic                    clk,
  input logic                    reset,
  pic_control_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_UNINIT, S_WAIT_ICW2, S_WAIT_ICW3, S_WAIT_ICW4, S_READY} init_st_t;
  typedef enum logic [2:0] {I_IDLE, I_IRQ, I_ACK1, I_WAIT2, I_ACK2} inta_st_t;

  localparam logic [3:0] TMO = 4'(ACK_TIMEOUT - 1);

  init_st_t   init_st_q;
  inta_st_t   inta_st_q;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q, ocw2_q, ocw3_q;
  logic       int_q, rp_q, sv_q, co_q, second_ack_q, ack_err_q;
  logic       rp_sh_q, sv_sh_q, co_sh_q;
  logic [3:0] rp_tmr_q, sv_tmr_q, co_tmr_q;
  logic       inta_prev_q, rise_seen_q;

  logic fall, rise, icw1_wr;
  logic rp_ack, sv_ack, co_ack, rp_to;

  assign fall    = inta_prev_q & ~bus.intaN;
  assign rise    = ~inta_prev_q & bus.intaN;
  assign icw1_wr = bus.wrEn & ~bus.a0 & bus.dataIn[4];

  // An ack "arrives" when its level differs from the value seen at the last completion.
  assign rp_ack = rp_q & (bus.readPriorityAck != rp_sh_q);
  assign sv_ack = sv_q & (bus.sendVectorAck != sv_sh_q);
  assign co_ack = co_q & (bus.changeInOCW2Ack != co_sh_q);
  assign rp_to  = rp_q & ~rp_ack & (rp_tmr_q == TMO);

  always_ff @(posedge clk) begin
    if (reset) begin
      init_st_q    <= S_UNINIT;
      inta_st_q    <= I_IDLE;
      icw1_q       <= 8'h00;
      icw2_q       <= 8'h00;
      icw3_q       <= 8'h00;
      icw4_q       <= 8'h00;
      ocw1_q       <= 8'h00;
      ocw2_q       <= 8'h00;
      ocw3_q       <= 8'h0A;
      int_q        <= 1'b0;
      rp_q         <= 1'b0;
      sv_q         <= 1'b0;
      co_q         <= 1'b0;
      second_ack_q <= 1'b0;
      ack_err_q    <= 1'b0;
      rp_sh_q      <= bus.readPriorityAck;
      sv_sh_q      <= bus.sendVectorAck;
      co_sh_q      <= bus.changeInOCW2Ack;
      rp_tmr_q     <= 4'd0;
      sv_tmr_q     <= 4'd0;
      co_tmr_q     <= 4'd0;
      inta_prev_q  <= 1'b1;
      rise_seen_q  <= 1'b0;
    end else begin
      inta_prev_q  <= bus.intaN;
      second_ack_q <= 1'b0;

      if (rp_ack) begin
        rp_q <= 1'b0; rp_sh_q <= bus.readPriorityAck;
      end else if (rp_q) begin
        if (rp_tmr_q == TMO) begin rp_q <= 1'b0; ack_err_q <= 1'b1; end
        else rp_tmr_q <= rp_tmr_q + 4'd1;
      end
      if (sv_ack) begin
        sv_q <= 1'b0; sv_sh_q <= bus.sendVectorAck;
      end else if (sv_q) begin
        if (sv_tmr_q == TMO) begin sv_q <= 1'b0; ack_err_q <= 1'b1; end
        else sv_tmr_q <= sv_tmr_q + 4'd1;
      end
      if (co_ack) begin
        co_q <= 1'b0; co_sh_q <= bus.changeInOCW2Ack;
      end else if (co_q) begin
        if (co_tmr_q == TMO) begin co_q <= 1'b0; ack_err_q <= 1'b1; end
        else co_tmr_q <= co_tmr_q + 4'd1;
      end

      if (icw1_wr) begin
        // Re-initialisation wins over everything, including a same-cycle INTA edge.
        icw1_q    <= bus.dataIn;
        icw4_q    <= 8'h00;
        ocw1_q    <= 8'h00;
        init_st_q <= S_WAIT_ICW2;
        inta_st_q <= I_IDLE;
        int_q     <= 1'b0;
        rp_q      <= 1'b0;
        sv_q      <= 1'b0;
        co_q      <= 1'b0;
      end else begin
        if (bus.wrEn) begin
          case (init_st_q)
            S_WAIT_ICW2: if (bus.a0) begin
              icw2_q    <= bus.dataIn;
              init_st_q <= !icw1_q[1] ? S_WAIT_ICW3 : (icw1_q[0] ? S_WAIT_ICW4 : S_READY);
            end
            S_WAIT_ICW3: if (bus.a0) begin
              icw3_q    <= bus.dataIn;
              init_st_q <= icw1_q[0] ? S_WAIT_ICW4 : S_READY;
            end
            S_WAIT_ICW4: if (bus.a0) begin
              icw4_q    <= bus.dataIn;
              init_st_q <= S_READY;
            end
            S_READY: begin
              if (bus.a0) ocw1_q <= bus.dataIn;
              else if (bus.dataIn[4:3] == 2'b00) begin
                ocw2_q   <= bus.dataIn;
                co_q     <= 1'b1;
                co_tmr_q <= 4'd0;
              end else if (bus.dataIn[4:3] == 2'b01) ocw3_q <= bus.dataIn;
            end
            default: ;
          endcase
        end

        case (inta_st_q)
          I_IDLE: if (init_st_q == S_READY && bus.irqPending) begin
            inta_st_q <= I_IRQ;
            int_q     <= 1'b1;
          end
          I_IRQ: if (fall) begin
            inta_st_q   <= I_ACK1;
            int_q       <= 1'b0;
            rp_q        <= 1'b1;
            rp_tmr_q    <= 4'd0;
            rise_seen_q <= 1'b0;
          end
          I_ACK1: begin
            rise_seen_q <= rise_seen_q | rise;
            if ((~rp_q | rp_ack | rp_to) && (rise_seen_q | rise)) inta_st_q <= I_WAIT2;
          end
          I_WAIT2: if (fall) begin
            inta_st_q <= I_ACK2;
            sv_q      <= 1'b1;
            sv_tmr_q  <= 4'd0;
          end
          I_ACK2: if (rise) begin
            inta_st_q    <= I_IDLE;
            second_ack_q <= 1'b1;
            sv_q         <= 1'b0;
            if (sv_q && !sv_ack) ack_err_q <= 1'b1;
          end
          default: inta_st_q <= I_IDLE;
        endcase
      end
    end
  end

  assign bus.readIsr      = bus.rdEn & ~bus.a0 & (ocw3_q[1:0] == 2'b11) & (inta_st_q == I_IDLE);
  assign bus.dataBusEn    = bus.readIsr | ((inta_st_q == I_ACK2) & ~bus.intaN);
  assign bus.initDone     = (init_st_q == S_READY);
  assign bus.INT          = int_q;
  assign bus.readPriority = rp_q;
  assign bus.sendVector   = sv_q;
  assign bus.secondACK    = second_ack_q;
  assign bus.changeInOCW2 = co_q;
  assign bus.ackError     = ack_err_q;
  assign bus.ICW1         = icw1_q;
  assign bus.ICW2         = icw2_q;
  assign bus.ICW3         = icw3_q;
  assign bus.ICW4         = icw4_q;
  assign bus.OCW1         = ocw1_q;
  assign bus.OCW2         = ocw2_q;
  assign bus.OCW3         = ocw3_q;

endmodule

// File: tb/tb_pic_control_sequencer.sv
// Directed bench for pic_control_sequencer: init sequences, INTA handshake,
// ack timeout, OCW2 re-write, ICW1 abort and mid-sequence reset.
module tb_pic_control_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   n;

  pic_control_sequencer_if bus();

  pic_control_sequencer #(.ACK_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.wrEn = 1'b1; bus.a0 = a; bus.dataIn = d;
    tick();
    bus.wrEn = 1'b0; bus.a0 = 1'b0; bus.dataIn = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    bus.wrEn = 1'b0; bus.a0 = 1'b0; bus.dataIn = 8'h00; bus.rdEn = 1'b0;
    bus.intaN = 1'b1; bus.irqPending = 1'b0;
    bus.readPriorityAck = 1'b0; bus.sendVectorAck = 1'b0; bus.changeInOCW2Ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_int", bus.INT, 0);
    chk("rst_initdone", bus.initDone, 0);
    chk("rst_ocw3", bus.OCW3, 8'h0A);
    chk("rst_icw1", bus.ICW1, 0);
    chk("rst_ackerr", bus.ackError, 0);
    chk("rst_dbe", bus.dataBusEn, 0);

    // single mode, no ICW4
    wr(1'b0, 8'h12);
    chk("s_icw1", bus.ICW1, 8'h12);
    chk("s_initdone_early", bus.initDone, 0);
    wr(1'b1, 8'h20);
    chk("s_initdone", bus.initDone, 1);
    chk("s_icw2", bus.ICW2, 8'h20);
    chk("s_icw3", bus.ICW3, 0);
    chk("s_icw4", bus.ICW4, 0);
    chk("s_ocw1", bus.OCW1, 0);

    // full init with ignored a0=0 write in a wait state
    wr(1'b0, 8'h11);
    chk("f_initdone0", bus.initDone, 0);
    wr(1'b1, 8'h40);
    chk("f_initdone1", bus.initDone, 0);
    wr(1'b0, 8'h08);
    chk("f_ignored", bus.ICW1, 8'h11);
    wr(1'b1, 8'h04);
    chk("f_initdone2", bus.initDone, 0);
    wr(1'b1, 8'h03);
    chk("f_initdone3", bus.initDone, 1);
    chk("f_words", {bus.ICW1, bus.ICW2, bus.ICW3, bus.ICW4}, 32'h11400403);

    // ISR read path
    wr(1'b0, 8'h0B);
    chk("ocw3_wr", bus.OCW3, 8'h0B);
    bus.rdEn = 1'b1; #1;
    chk("readisr", bus.readIsr, 1);
    chk("readisr_dbe", bus.dataBusEn, 1);
    bus.rdEn = 1'b0; #1;
    chk("readisr_off", bus.readIsr, 0);

    // spurious INTA in IDLE
    bus.intaN = 1'b0; tick();
    chk("spur_rp", bus.readPriority, 0);
    bus.intaN = 1'b1; tick();

    // normal INTA sequence
    bus.irqPending = 1'b1; tick();
    chk("inta_int", bus.INT, 1);
    bus.irqPending = 1'b0; tick();
    chk("inta_int_latched", bus.INT, 1);
    bus.intaN = 1'b0; tick();
    chk("inta_rp", {bus.INT, bus.readPriority}, 2'b01);
    tick();
    chk("inta_rp_hold", bus.readPriority, 1);
    bus.readPriorityAck = 1'b1; tick();
    chk("inta_rp_done", bus.readPriority, 0);
    bus.intaN = 1'b1; tick();
    chk("inta_sv_wait", bus.sendVector, 0);
    bus.intaN = 1'b0; tick();
    chk("inta_sv", {bus.sendVector, bus.dataBusEn, bus.secondACK}, 3'b110);
    bus.sendVectorAck = 1'b1; tick();
    chk("inta_sv_done", {bus.sendVector, bus.dataBusEn}, 2'b01);
    bus.intaN = 1'b1; tick();
    chk("inta_2ack", {bus.secondACK, bus.dataBusEn}, 2'b10);
    tick();
    chk("inta_2ack_pulse", bus.secondACK, 0);
    chk("inta_noerr", bus.ackError, 0);

    // readPriority timeout
    bus.irqPending = 1'b1; tick();
    bus.irqPending = 1'b0;
    bus.intaN = 1'b0; tick();
    chk("to_rp_on", bus.readPriority, 1);
    n = 0;
    while (bus.readPriority === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_len", n, 15);
    chk("to_ackerr", bus.ackError, 1);

    // ICW1 abort while in ACK2, coinciding with the INTA rise
    bus.intaN = 1'b1; tick();
    bus.intaN = 1'b0; tick();
    chk("ab_sv_on", bus.sendVector, 1);
    bus.intaN = 1'b1;
    wr(1'b0, 8'h12);
    chk("ab_outs", {bus.INT, bus.readPriority, bus.sendVector, bus.secondACK, bus.initDone}, 5'b0);
    chk("ab_ackerr_sticky", bus.ackError, 1);
    wr(1'b1, 8'h20);
    chk("ab_reinit", bus.initDone, 1);

    // OCW2 re-write while pending, single toggle completes
    wr(1'b0, 8'h20);
    chk("o2_a", {bus.OCW2, 7'd0, bus.changeInOCW2}, 16'h2001);
    tick();
    chk("o2_hold", bus.changeInOCW2, 1);
    wr(1'b0, 8'h60);
    chk("o2_b", {bus.OCW2, 7'd0, bus.changeInOCW2}, 16'h6001);
    bus.changeInOCW2Ack = 1'b1; tick();
    chk("o2_done", bus.changeInOCW2, 0);
    tick();
    chk("o2_stays", bus.changeInOCW2, 0);

    // synchronous reset mid-sequence
    bus.irqPending = 1'b1; tick();
    bus.irqPending = 1'b0;
    bus.intaN = 1'b0; tick();
    chk("mr_rp_on", bus.readPriority, 1);
    reset = 1'b1; tick();
    chk("mr_outs", {bus.INT, bus.readPriority, bus.sendVector, bus.secondACK,
                    bus.changeInOCW2, bus.initDone, bus.ackError, bus.dataBusEn}, 8'h00);
    chk("mr_words", {bus.ICW1, bus.OCW2, bus.OCW3}, 24'h00000A);
    reset = 1'b0;
    bus.intaN = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pic_control_sequencer.md
Name: pic_control_sequencer

Overview:
- Control-logic sequencer for the 8259A-style PIC. Sits between the host bus (write strobes, A0, INTA) and the in-service register, priority resolver and mask logic.
- Runs the ICW1–ICW4 initialization sequence and holds the ICW/OCW registers.
- Drives the two-pulse INTA acknowledge sequence. Issues the toggle-acknowledged requests readPriority, sendVector and changeInOCW2, and the secondACK pulse.

Parameters:
ACK_TIMEOUT, 15, cycles to wait for an ack toggle before abandoning a request (4-bit counter, range 1..15)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wrEn  in  1  one-cycle host write strobe, synchronous to clk
a0  in  1  host address bit A0
dataIn  in  8  host write data
rdEn  in  1  host read strobe (level)
intaN  in  1  interrupt acknowledge from CPU, active low, already synchronised
irqPending  in  1  priority resolver reports an unmasked request outranking the ISR
readPriorityAck  in  1  toggles when the ISR has latched the priority
sendVectorAck  in  1  toggles when the ISR has driven the vector
changeInOCW2Ack  in  1  toggles when the ISR has consumed OCW2
INT  out  1  interrupt request to CPU
readPriority  out  1  request: ISR latches the winning IR
sendVector  out  1  request: ISR drives the vector
secondACK  out  1  one-cycle pulse at the end of the second INTA
changeInOCW2  out  1  request: ISR processes OCW2
readIsr  out  1  ISR drives its value onto the data buffer
dataBusEn  out  1  data bus output enable
initDone  out  1  ICW sequence complete
ackError  out  1  sticky: an ack timeout occurred
ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3  out  8 each  registered command words

Behaviour:
- Reset: all outputs and registers are 0, except OCW3 = 8'h0A (read IRR by default). The internal intaN history register resets to 1. Each ack shadow register is loaded from its ack input.
- Init FSM states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
  - A write with a0=0 and dataIn[4]=1 loads ICW1 from any state. It also clears ICW4, OCW1 and initDone, moves the FSM to WAIT_ICW2, and aborts any INTA sequence (INT and all requests drop the next cycle).
  - WAIT_ICW2: a write with a0=1 loads ICW2. The next state is WAIT_ICW3 if ICW1[1]=0, else WAIT_ICW4 if ICW1[0]=1, else READY.
  - WAIT_ICW3: a write with a0=1 loads ICW3, then goes to WAIT_ICW4 if ICW1[0]=1, else READY.
  - WAIT_ICW4: a write with a0=1 loads ICW4, then goes to READY.
  - Writes with a0=0 in the WAIT states (other than ICW1) are ignored.
  - initDone = 1 exactly in READY.
- READY writes:
  - a0=1 loads OCW1.
  - a0=0 with dataIn[4:3]=00 loads OCW2 and asserts changeInOCW2.
  - a0=0 with dataIn[4:3]=01 loads OCW3.
- Toggle handshake (the same rule for all three requests):
  - The request is a level, asserted the cycle after its trigger.
  - It deasserts the cycle after its ack differs from the shadow; the shadow is updated at that point.
  - If no toggle arrives within ACK_TIMEOUT cycles, the request drops and ackError sets.
  - ackError clears only on reset.
  - A second OCW2 write while changeInOCW2 is pending updates OCW2 and restarts the timeout. A single ack completes the request.
- INTA edge detection: fall = prev & ~intaN; rise = ~prev & intaN.
- INTA FSM states: IDLE, IRQ, ACK1, WAIT2, ACK2.
  - IDLE -> IRQ when initDone & irqPending. INT = 1 from IRQ until the first fall.
  - If irqPending drops while in IRQ, INT stays high (latched until acknowledged).
  - IRQ -> ACK1 on fall. INT drops and readPriority asserts.
  - ACK1 -> WAIT2 once readPriority completes (ack or timeout) and a rise has been seen, in either order.
  - WAIT2 -> ACK2 on fall. sendVector asserts and dataBusEn = ~intaN.
  - ACK2 -> IDLE on rise. secondACK pulses for exactly one cycle that cycle. A still-pending sendVector is dropped and ackError sets.
  - A fall in IDLE (spurious INTA) is ignored.
  - An ICW1 write mid-sequence returns the FSM to IDLE without a secondACK pulse.
- readIsr = rdEn & a0=0 & OCW3[1:0]=2'b11 & INTA FSM in IDLE. dataBusEn is also high whenever readIsr is high.
- Simultaneous wrEn and an INTA edge are both processed in the same cycle.

Test Plan:
- Init, single mode, no ICW4: write ICW1 = 0x12 then ICW2 = 0x20 (a0=1) -> initDone=1 two cycles after the first write; ICW3=0, ICW4=0, OCW1=0.
- Full init: ICW1 = 0x11, ICW2 = 0x40, ICW3 = 0x04, ICW4 = 0x03 -> each word is stored; initDone rises only after the ICW4 write.
- INTA sequence: irqPending=1 -> INT=1 next cycle. First INTA low -> readPriority=1 until the ack toggles 2 cycles later, and INT=0. Second INTA low -> sendVector=1 and dataBusEn=1. INTA high -> secondACK is a one-cycle pulse and the FSM returns to IDLE.
- Timeout: hold readPriorityAck constant -> readPriority drops after 15 cycles and ackError=1 until reset.
- OCW2 write 0x20 in READY -> OCW2=0x20, changeInOCW2=1 until the ack toggles. A second write of 0x60 before the ack -> OCW2=0x60, and one toggle clears the request.
- Reset/abort: an ICW1 write between the two INTA pulses -> INT, readPriority and sendVector are 0 next cycle, no secondACK, initDone=0. Synchronous reset asserted mid-sequence -> all outputs 0 the following cycle.
